// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an async FIFO on its read clock. Each popped byte is
// sent as one UART frame: start bit, data LSB first, optional parity, stop.
// R_INC is the FIFO pop strobe, so the FIFO's EMPTY and RD_DATA connect directly.
// Optional build macro FIFO_UART_TX_TWO_STOP_EN: two stop bits per frame.
// The decision to start the next frame then moves to the second stop cycle.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  R_INC,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_TWO_STOP_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic                  par_en_q, par_en_next;
   logic                  par_bit_q, par_bit_next;
   logic                  tx_q, tx_next;
   logic                  busy_q, busy_next;
   logic                  r_inc_q, r_inc_next;
   logic                  capture;

   // All outputs come straight from flops.
   // The line is glitch-free, and the FIFO sees a clean one-cycle pop strobe.
   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;
   assign R_INC  = r_inc_q;

   // State and datapath registers.
   // Reset drops the line to idle immediately, even mid-frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         cnt       <= '0;
         data_reg  <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         r_inc_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         data_reg  <= data_next;
         par_en_q  <= par_en_next;
         par_bit_q <= par_bit_next;
         tx_q      <= tx_next;
         busy_q    <= busy_next;
         r_inc_q   <= r_inc_next;
      end
   end

   // Next-state and next-output logic.
   // TX_OUT is registered, so each branch computes the bit for the following
   // cycle. Capture overrides everything: latch the word and the parity
   // settings, then start a new frame.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      data_next    = data_reg;
      par_en_next  = par_en_q;
      par_bit_next = par_bit_q;
      tx_next      = tx_q;
      busy_next    = busy_q;
      r_inc_next   = 1'b0;
      capture      = 1'b0;

      case (state)
         IDLE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (!EMPTY) begin
               capture = 1'b1;
            end
         end
         START: begin
            state_next = DATA;
            cnt_next   = '0;
            tx_next    = data_reg[0];
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_next = '0;
               if (par_en_q) begin
                  state_next = PARITY;
                  tx_next    = par_bit_q;
               end else begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
               tx_next  = data_reg[cnt_next];
            end
         end
         PARITY: begin
            state_next = STOP;
            tx_next    = 1'b1;
         end
`ifdef FIFO_UART_TX_TWO_STOP_EN
         STOP: begin
            state_next = STOP2;
            tx_next    = 1'b1;
         end
         STOP2: begin
            if (!EMPTY) begin
               capture = 1'b1;
            end else begin
               state_next = IDLE;
               tx_next    = 1'b1;
               busy_next  = 1'b0;
            end
         end
`else
         STOP: begin
            if (!EMPTY) begin
               capture = 1'b1;
            end else begin
               state_next = IDLE;
               tx_next    = 1'b1;
               busy_next  = 1'b0;
            end
         end
`endif
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase

      if (capture) begin
         state_next   = START;
         cnt_next     = '0;
         data_next    = RD_DATA;
         par_en_next  = PAR_EN;
         par_bit_next = (^RD_DATA) ^ PAR_TYP;
         tx_next      = 1'b0;
         busy_next    = 1'b1;
         r_inc_next   = 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed vectors with hand-computed UART frames.
// Stimulus pushes each byte into a behavioural FIFO and its expected bits
// into a scoreboard queue. A negedge monitor compares every line bit while
// BUSY is high, and checks the idle and reset levels otherwise.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_TWO_STOP_EN
   localparam int STOP_EXTRA = 1;
`else
   localparam int STOP_EXTRA = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       EMPTY;
   logic [7:0] RD_DATA;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       R_INC;
   logic       TX_OUT;
   logic       BUSY;

   int   tests_run  = 0;
   int   fail_count = 0;
   int   pop_count  = 0;
   logic [7:0] fifo_q[$];
   logic       exp_q[$];
   logic       prev_r_inc = 1'b0;

   fifo_uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .EMPTY  (EMPTY),
      .RD_DATA(RD_DATA),
      .PAR_EN (PAR_EN),
      .PAR_TYP(PAR_TYP),
      .R_INC  (R_INC),
      .TX_OUT (TX_OUT),
      .BUSY   (BUSY)
   );

   // 10 ns bit clock
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Queue a byte in the FIFO model and its frame bits (time order, MSB first) in the scoreboard
   task automatic applyStimulus(input logic [7:0] data, input logic [11:0] bits, input int len);
      fifo_q.push_back(data);
      for (int i = len - 1; i >= 0; i--) begin
         exp_q.push_back(bits[i]);
      end
      for (int i = 0; i < STOP_EXTRA; i++) begin
         exp_q.push_back(1'b1);
      end
   endtask

   task automatic waitIdle(input int max_cycles);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(posedge CLK);
         #1;
         if (!BUSY && exp_q.size() == 0 && fifo_q.size() == 0) done = 1'b1;
      end
      checkOutput("wait_idle", done, 1);
   endtask

   task automatic waitRinc(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles && !ok; i++) begin
         @(posedge CLK);
         #1;
         if (R_INC) ok = 1'b1;
      end
   endtask

   // Measure the distance between two consecutive pops; BUSY must not drop in between
   task automatic checkSpacing(input int expected_len, input string name);
      bit ok;
      bit busy_ok;
      bit seen;
      int k;
      waitRinc(100, ok);
      checkOutput({name, "_first_pop"}, ok, 1);
      busy_ok = 1'b1;
      seen    = 1'b0;
      k       = 0;
      while (k < 40 && !seen) begin
         @(posedge CLK);
         #1;
         k++;
         if (!BUSY) busy_ok = 1'b0;
         if (R_INC) seen = 1'b1;
      end
      checkOutput(name, k, expected_len);
      checkOutput({name, "_busy_held"}, busy_ok, 1);
   endtask

   // FIFO model: pop on R_INC, then present the new head and empty flag
   always @(negedge CLK) begin
      if (RST && R_INC) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_count++;
      end
      EMPTY   = (fifo_q.size() == 0);
      RD_DATA = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   end

   // Monitor: compare line bits against the scoreboard, check idle/reset levels
   always @(negedge CLK) begin
      if (!RST) begin
         checkOutput("reset_tx", TX_OUT, 1);
         checkOutput("reset_busy", BUSY, 0);
         checkOutput("reset_r_inc", R_INC, 0);
         exp_q.delete();
         prev_r_inc = 1'b0;
      end else begin
         if (R_INC) checkOutput("r_inc_width", prev_r_inc, 0);
         prev_r_inc = R_INC;
         if (BUSY) begin
            if (exp_q.size() == 0) checkOutput("unexpected_bit", 1, 0);
            else checkOutput("frame_bit", TX_OUT, exp_q.pop_front());
         end else begin
            checkOutput("idle_tx", TX_OUT, 1);
            checkOutput("idle_r_inc", R_INC, 0);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      RST     = 1'b1;
      EMPTY   = 1'b1;
      RD_DATA = 8'h00;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      #2 RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;

      // Idle with empty FIFO
      repeat (50) @(posedge CLK);
      #1;
      checkOutput("idle_pops", pop_count, 0);

      // 0xA5 even parity
      PAR_EN  = 1'b1;
      PAR_TYP = 1'b0;
      applyStimulus(8'hA5, 12'b01010010101, 11);
      waitIdle(60);
      checkOutput("pops_even", pop_count, 1);

      // 0xA5 odd parity
      PAR_TYP = 1'b1;
      applyStimulus(8'hA5, 12'b01010010111, 11);
      waitIdle(60);

      // 0xA5 without parity
      PAR_EN = 1'b0;
      applyStimulus(8'hA5, 12'b0101001011, 10);
      waitIdle(60);
      checkOutput("pops_single", pop_count, 3);

      // Back-to-back 0x10, 0x20
      applyStimulus(8'h10, 12'b0000010001, 10);
      applyStimulus(8'h20, 12'b0000001001, 10);
      checkSpacing(10 + STOP_EXTRA, "b2b_spacing");
      waitIdle(60);
      checkOutput("pops_b2b", pop_count, 5);

      // PAR_EN dropped mid-frame: 0x0F still carries its even parity bit
      PAR_EN  = 1'b1;
      PAR_TYP = 1'b0;
      applyStimulus(8'h0F, 12'b01111000001, 11);
      waitRinc(60, ok);
      checkOutput("pop_0f", ok, 1);
      repeat (3) @(posedge CLK);
      #1 PAR_EN = 1'b0;
      waitIdle(60);

      // Reset during the second data bit of 0x33
      applyStimulus(8'h33, 12'b0110011001, 10);
      waitRinc(60, ok);
      checkOutput("pop_33", ok, 1);
      @(posedge CLK);
      @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      checkOutput("rst_imm_tx", TX_OUT, 1);
      checkOutput("rst_imm_busy", BUSY, 0);
      checkOutput("rst_imm_r_inc", R_INC, 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      checkOutput("pops_after_rst", pop_count, 7);

      // Two 0x55 frames back-to-back (one or two stop bits depending on build)
      PAR_EN = 1'b0;
      applyStimulus(8'h55, 12'b0101010101, 10);
      applyStimulus(8'h55, 12'b0101010101, 10);
      checkSpacing(10 + STOP_EXTRA, "spacing_55");
      waitIdle(60);

      checkOutput("exp_queue_empty", exp_q.size(), 0);
      checkOutput("pops_total", pop_count, 9);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
